// File: rtl/fp_add_sequencer.sv
// Multi-cycle single-precision add/subtract: unpack, serial align, add, serial normalize, pack.
// Define FPU_SEQ_FAST_ALIGN_EN to align in one cycle with a barrel shifter instead of 1 bit per cycle.
module fp_add_sequencer #(
  parameter int unsigned MAX_ALIGN = 26
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        sub_i,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        nan_o,
  output logic        inf_o,
  output logic        zero_o
);

  // Handshake: start_i is accepted only on a cycle with busy_o=0; done_o pulses for one
  // cycle (the PACK cycle) and result_o/flags stay valid until the next done_o.
  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK
  } state_t;

  localparam logic [7:0]  MAX_ALIGN_W = 8'(MAX_ALIGN);
  localparam logic [31:0] QNAN        = 32'h7FC0_0000;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [7:0]  exp_q, exp_d, shift_q, shift_d;
  logic [24:0] mant_a_q, mant_a_d, mant_b_q, mant_b_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;

  logic        x_s, y_s;
  logic [7:0]  x_e, y_e, diff;
  logic [22:0] x_f, y_f;
  logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_big;
  logic [24:0] x_m, y_m, sum, norm_m;
  logic [7:0]  norm_e;
  logic        fin;
  logic [31:0] fin_res;
  logic [2:0]  fin_flags;

  // y_q already carries the effective sign (y[31]^sub captured at accept).
  assign {x_s, x_e, x_f} = x_q;
  assign {y_s, y_e, y_f} = y_q;
  assign x_zero = (x_e == 8'h00);
  assign y_zero = (y_e == 8'h00);
  assign x_inf  = (x_e == 8'hFF) && (x_f == 23'd0);
  assign y_inf  = (y_e == 8'hFF) && (y_f == 23'd0);
  assign x_nan  = (x_e == 8'hFF) && (x_f != 23'd0);
  assign y_nan  = (y_e == 8'hFF) && (y_f != 23'd0);
  assign x_big  = (x_e > y_e) || ((x_e == y_e) && (x_f >= y_f));
  assign x_m    = {2'b01, x_f};
  assign y_m    = {2'b01, y_f};
  assign diff   = x_big ? (x_e - y_e) : (y_e - x_e);

  // mant_a holds the larger magnitude, so the difference never goes negative.
  assign sum    = (sign_a_q == sign_b_q) ? (mant_a_q + mant_b_q) : (mant_a_q - mant_b_q);
  assign norm_m = mant_a_q[24] ? (mant_a_q >> 1) : (mant_a_q << 1);
  assign norm_e = mant_a_q[24] ? (exp_q + 8'd1) : (exp_q - 8'd1);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    exp_d     = exp_q;
    shift_d   = shift_q;
    mant_a_d  = mant_a_q;
    mant_b_d  = mant_b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    nan_d     = nan_q;
    inf_d     = inf_q;
    zero_d    = zero_q;
    fin       = 1'b0;
    fin_res   = 32'd0;
    fin_flags = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d     = x_i;
          y_d     = {y_i[31] ^ sub_i, y_i[30:0]};
          busy_d  = 1'b1;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        if (x_nan || y_nan || (x_inf && y_inf && (x_s != y_s))) begin
          fin = 1'b1; fin_res = QNAN; fin_flags = 3'b100;
        end else if (x_inf) begin
          fin = 1'b1; fin_res = {x_s, 8'hFF, 23'd0}; fin_flags = 3'b010;
        end else if (y_inf) begin
          fin = 1'b1; fin_res = {y_s, 8'hFF, 23'd0}; fin_flags = 3'b010;
        end else if (x_zero && y_zero) begin
          fin = 1'b1; fin_res = {x_s & y_s, 31'd0}; fin_flags = 3'b001;
        end else if (x_zero) begin
          fin = 1'b1; fin_res = y_q;
        end else if (y_zero) begin
          fin = 1'b1; fin_res = x_q;
        end else begin
          sign_a_d = x_big ? x_s : y_s;
          sign_b_d = x_big ? y_s : x_s;
          exp_d    = x_big ? x_e : y_e;
          mant_a_d = x_big ? x_m : y_m;
          mant_b_d = x_big ? y_m : x_m;
          shift_d  = diff;
          state_d  = (diff != 8'd0) ? S_ALIGN : S_ADD;
        end
      end
      S_ALIGN: begin
        if (shift_q >= MAX_ALIGN_W) begin
          mant_b_d = 25'd0;
          shift_d  = 8'd0;
          state_d  = S_ADD;
        end else begin
`ifdef FPU_SEQ_FAST_ALIGN_EN
          mant_b_d = mant_b_q >> shift_q;
          shift_d  = 8'd0;
          state_d  = S_ADD;
`else
          mant_b_d = mant_b_q >> 1;
          shift_d  = shift_q - 8'd1;
          if (shift_q == 8'd1) state_d = S_ADD;
`endif
        end
      end
      S_ADD: begin
        if (sum == 25'd0) begin
          fin = 1'b1; fin_res = 32'd0; fin_flags = 3'b001;
        end else if (sum[24] || !sum[23]) begin
          mant_a_d = sum;
          state_d  = S_NORM;
        end else begin
          fin = 1'b1; fin_res = {sign_a_q, exp_q, sum[22:0]};
        end
      end
      S_NORM: begin
        if (norm_e == 8'hFF) begin
          fin = 1'b1; fin_res = {sign_a_q, 8'hFF, 23'd0}; fin_flags = 3'b010;
        end else if (norm_e == 8'h00) begin
          fin = 1'b1; fin_res = {sign_a_q, 31'd0}; fin_flags = 3'b001;
        end else if (!norm_m[24] && norm_m[23]) begin
          fin = 1'b1; fin_res = {sign_a_q, norm_e, norm_m[22:0]};
        end else begin
          mant_a_d = norm_m;
          exp_d    = norm_e;
        end
      end
      S_PACK: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      result_d                = fin_res;
      {nan_d, inf_d, zero_d}  = fin_flags;
      done_d                  = 1'b1;
      state_d                 = S_PACK;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      exp_q    <= '0;
      shift_q  <= '0;
      mant_a_q <= '0;
      mant_b_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      exp_q    <= exp_d;
      shift_q  <= shift_d;
      mant_a_q <= mant_a_d;
      mant_b_q <= mant_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      nan_q    <= nan_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign nan_o    = nan_q;
  assign inf_o    = inf_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed-vector bench for fp_add_sequencer: result, flags and accept-to-done latency.
module tb_fp_add_sequencer;

`ifdef FPU_SEQ_FAST_ALIGN_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        sub_i;
  logic [31:0] x_i;
  logic [31:0] y_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        nan_o;
  logic        inf_o;
  logic        zero_o;

  always #5 clk_i = ~clk_i;

  fp_add_sequencer #(.MAX_ALIGN(26)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .sub_i(sub_i),
    .x_i(x_i), .y_i(y_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .nan_o(nan_o), .inf_o(inf_o), .zero_o(zero_o)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        sub;
    logic [31:0] res;
    logic [2:0]  flags;   // {nan, inf, zero}
    int          lat;
  } vec_t;

  localparam int NVEC = 14;
  vec_t        vecs[NVEC];
  int          checks = 0;
  int          errors = 0;
  logic [34:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one operation and checks it. With noise set, start_i stays high and the
  // operand/sub inputs keep changing for the whole operation, including the PACK edge.
  task automatic run_op(input vec_t v, input bit noise);
    logic [34:0] e;
    bit          seen;
    int          lat;
    @(negedge clk_i);
    start_i = 1'b1; x_i = v.x; y_i = v.y; sub_i = v.sub;
    exp_q.push_back({v.res, v.flags});
    @(posedge clk_i);
    #1;
    if (noise) begin
      x_i = $urandom; y_i = $urandom; sub_i = ~sub_i;
    end else begin
      start_i = 1'b0;
    end
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk_i);
      if (c == 1) check("busy_after_accept", {31'd0, busy_o}, 32'd1);
      if (done_o) begin
        seen = 1'b1;
        lat  = c;
      end else if (noise) begin
        x_i = $urandom; y_i = $urandom; sub_i = ~sub_i;
      end
    end
    e = exp_q.pop_front();
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("result", result_o, e[34:3]);
      check("flags", {29'd0, nan_o, inf_o, zero_o}, {29'd0, e[2:0]});
      check("latency", lat, v.lat);
      check("busy_in_pack", {31'd0, busy_o}, 32'd1);
    end
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("busy_after_pack", {31'd0, busy_o}, 32'd0);
    check("done_pulse_len", {31'd0, done_o}, 32'd0);
    check("result_held", result_o, e[34:3]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd0);
    check({tag, "_result"}, result_o, 32'd0);
    check({tag, "_flags"}, {29'd0, nan_o, inf_o, zero_o}, 32'd0);
  endtask

  initial begin
    int   dones;
    vec_t v;
    vecs[0]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000, 4};
    vecs[1]  = '{32'h3F80_0000, 32'h3A80_0000, 1'b0, 32'h3F80_2000, 3'b000, FAST ? 4 : 13};
    vecs[2]  = '{32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000, 3'b000, 4};
    vecs[3]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3'b001, 3};
    vecs[4]  = '{32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 3'b100, 2};
    vecs[5]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 3'b100, 2};
    vecs[6]  = '{32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 3'b010, 2};
    vecs[7]  = '{32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 3'b000, 2};
    vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 3'b001, 2};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 3'b001, 2};
    vecs[10] = '{32'h3F80_0000, 32'h3300_0000, 1'b0, 32'h3F80_0000, 3'b000, FAST ? 4 : 28};
    vecs[11] = '{32'h3F80_0000, 32'h3280_0000, 1'b0, 32'h3F80_0000, 3'b000, 4};
    vecs[12] = '{32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 3'b000, 5};
    vecs[13] = '{32'h00C0_0000, 32'h0080_0000, 1'b1, 32'h0000_0000, 3'b001, 4};

    rst_n_i = 1'b0; start_i = 1'b0; sub_i = 1'b0; x_i = '0; y_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_outputs_zero("reset");
    rst_n_i = 1'b1;

    for (int i = 0; i < NVEC; i++) run_op(vecs[i], 1'b0);

    // Overflow to infinity while start_i is held and operands wander.
    v = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b010, 4};
    run_op(v, 1'b1);
    // Denormal operand flushed to zero.
    v = '{32'h0040_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 3'b000, 2};
    run_op(v, 1'b1);

    // Asynchronous reset during ALIGN aborts the operation.
    @(negedge clk_i);
    start_i = 1'b1; x_i = 32'h3F80_0000; y_i = 32'h3A80_0000; sub_i = 1'b0;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("busy_in_align", {31'd0, busy_o}, 32'd1);
    rst_n_i = 1'b0;
    #1;
    check_outputs_zero("abort");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    check("no_done_after_abort", dones, 0);
    check("idle_after_abort", {31'd0, busy_o}, 32'd0);
    run_op(vecs[1], 1'b0);
    run_op(vecs[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
